keypad_digit_entry: RTL and testbench

Parametrised keypad front end for the timer-entry path. It synchronises and debounces a raw one-hot keypad, encodes the pressed key to a 4-bit code, and emits one strobe per press. Digit keys are accumulated into a DIGITS-deep BCD shift register that feeds timer preset/control logic. It generalises the combinational keypad priority encoder: configurable key count, debounce, press/release tracking and multi-digit buffering.

---
 rtl/keypad_digit_entry.sv | 257 +++++++++++++++++++++++++
 tb/tb_keypad_digit_entry.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_entry.sv
// keypad_digit_entry
// Keypad front end for the timer-entry path. Raw one-hot key lines are
// synchronised (2 flops), debounced for press and release, encoded to a
// 4-bit code and announced with a single-cycle strobe per press. Digit keys
// (codes 0..9) shift into a DIGITS-deep BCD entry register, newest digit in
// bits [3:0].
//
// Parameters:
//   NUM_KEYS        number of keypad lines (2..16), key i encodes to code i
//   DIGITS          BCD digits held in the entry register (1..8)
//   DEBOUNCE_CYCLES stable synchronised samples needed for press and release
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   keypad     raw key lines, active-high, asynchronous to clk
//   enablen    active-low enable; high forces the FSM to IDLE
//   clear      synchronous clear of digit register and digit count
//   keyCode    code of last accepted key
//   keyStrobe  one-cycle pulse per accepted press
//   keyValidn  low while an accepted key is held or releasing
//   digits     BCD entry, digit 0 = bits [3:0] = most recent
//   digitCount number of digits entered, saturates at DIGITS
//   full       high when digitCount == DIGITS
module keypad_digit_entry #(
    parameter int NUM_KEYS        = 10,
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_KEYS-1:0]   keypad,
    input  logic                  enablen,
    input  logic                  clear,
    output logic [3:0]            keyCode,
    output logic                  keyStrobe,
    output logic                  keyValidn,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            digitCount,
    output logic                  full
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value at which one more stable sample completes the debounce.
    localparam logic [CW-1:0] C_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    C_DIGITS = 4'(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [NUM_KEYS-1:0]   r_sync1;
    logic [NUM_KEYS-1:0]   r_sync2;
    logic [NUM_KEYS-1:0]   r_latched;
    logic [CW-1:0]         r_cnt;
    logic [3:0]            r_keyCode;
    logic                  r_keyStrobe;
    logic                  r_keyValidn;
    logic [4*DIGITS-1:0]   r_digits;
    logic [3:0]            r_count;
    logic                  r_full;

    logic                  w_single;
    logic                  w_none;
    logic                  w_match;
    logic                  w_enter_held;
    logic [3:0]            w_code;
    logic [4*DIGITS-1:0]   w_digits_next;
    logic [3:0]            w_count_next;

    // Index of the set bit of a one-hot pattern (lowest set bit wins).
    function automatic logic [3:0] f_encode(input logic [NUM_KEYS-1:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                code = 4'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    // True when exactly one key line is active.
    function automatic logic f_is_single(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

    // Shift a new BCD digit into position 0, dropping the oldest digit.
    function automatic logic [4*DIGITS-1:0] f_shift_in(input logic [4*DIGITS-1:0] d,
                                                       input logic [3:0]          code);
        logic [4*DIGITS-1:0] r;
        r = d;
        for (int i = DIGITS - 1; i > 0; i--) begin
            r[4*i +: 4] = d[4*(i-1) +: 4];
        end
        r[3:0] = code;
        return r;
    endfunction

    // Classify the synchronised key pattern and detect the HELD-entry edge.
    always_comb begin
        w_single     = f_is_single(r_sync2);
        w_none       = (r_sync2 == '0);
        w_match      = (r_sync2 == r_latched);
        w_enter_held = 1'b0;
        w_code       = f_encode(r_latched);
        if (enablen) begin
            w_enter_held = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // With a single-sample debounce the press is accepted straight from IDLE.
                    w_enter_held = w_single && (DEBOUNCE_CYCLES == 1);
                    w_code       = f_encode(r_sync2);
                end
                S_DEBOUNCE: begin
                    w_enter_held = w_match && (r_cnt == C_LAST);
                end
                default: begin
                    w_enter_held = 1'b0;
                end
            endcase
        end
    end

    // Next value of the digit register and count; clear overrides an accept.
    always_comb begin
        w_digits_next = r_digits;
        w_count_next  = r_count;
        if (clear) begin
            w_digits_next = '0;
            w_count_next  = 4'd0;
        end else if (w_enter_held && (w_code < 4'd10)) begin
            w_digits_next = f_shift_in(r_digits, w_code);
            if (r_count < C_DIGITS) begin
                w_count_next = r_count + 4'd1;
            end else begin
                w_count_next = r_count;
            end
        end else begin
            w_digits_next = r_digits;
            w_count_next  = r_count;
        end
    end

    // Synchroniser plus press/release debounce FSM with registered key outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_state     <= S_IDLE;
            r_latched   <= '0;
            r_cnt       <= '0;
            r_keyCode   <= 4'd0;
            r_keyStrobe <= 1'b0;
            r_keyValidn <= 1'b1;
        end else begin
            r_sync1     <= keypad;
            r_sync2     <= r_sync1;
            r_keyStrobe <= 1'b0;
            if (enablen) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_keyValidn <= 1'b1;
            end else if (w_enter_held) begin
                r_state     <= S_HELD;
                r_cnt       <= '0;
                r_keyCode   <= w_code;
                r_keyStrobe <= 1'b1;
                r_keyValidn <= 1'b0;
                if (r_state == S_IDLE) begin
                    r_latched <= r_sync2;
                end else begin
                    r_latched <= r_latched;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_single) begin
                            r_state   <= S_DEBOUNCE;
                            r_latched <= r_sync2;
                            r_cnt     <= CW'(1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (w_match) begin
                            r_cnt <= r_cnt + CW'(1);
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    S_HELD: begin
                        if (w_none) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                r_state     <= S_IDLE;
                                r_cnt       <= '0;
                                r_keyValidn <= 1'b1;
                            end else begin
                                r_state <= S_RELEASE;
                                r_cnt   <= CW'(1);
                            end
                        end else begin
                            r_state <= S_HELD;
                        end
                    end
                    S_RELEASE: begin
                        if (!w_none) begin
                            // Key came back during release: resume HELD without a new strobe.
                            r_state <= S_HELD;
                            r_cnt   <= '0;
                        end else if (r_cnt == C_LAST) begin
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_keyValidn <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Digit entry register, digit count and full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= '0;
            r_count  <= 4'd0;
            r_full   <= 1'b0;
        end else begin
            r_digits <= w_digits_next;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == C_DIGITS);
        end
    end

    assign keyCode    = r_keyCode;
    assign keyStrobe  = r_keyStrobe;
    assign keyValidn  = r_keyValidn;
    assign digits     = r_digits;
    assign digitCount = r_count;
    assign full       = r_full;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry: a default instance (10 keys)
// and a 12-key instance. Every accepted-press expectation is queued when the
// press is driven and compared when the DUT raises keyStrobe.
module tb_keypad_digit_entry;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] dig;
        logic [3:0]  cnt;
        logic        full;
    } exp_t;

    typedef struct {
        int          key;
        int          hold;
        logic [3:0]  code;
        logic [15:0] dig;
        logic [3:0]  cnt;
        logic        full;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  keypad_a;
    logic        enablen_a, clear_a;
    logic [3:0]  keyCode_a, digitCount_a;
    logic        keyStrobe_a, keyValidn_a, full_a;
    logic [15:0] digits_a;
    logic [11:0] keypad_b;
    logic        enablen_b, clear_b;
    logic [3:0]  keyCode_b, digitCount_b;
    logic        keyStrobe_b, keyValidn_b, full_b;
    logic [15:0] digits_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_strobe_a = 0;
    int   n_strobe_b = 0;
    bit   sa, sb;

    always #5 clk = ~clk;

    keypad_digit_entry dut_a (
        .clk(clk), .rst(rst), .keypad(keypad_a), .enablen(enablen_a), .clear(clear_a),
        .keyCode(keyCode_a), .keyStrobe(keyStrobe_a), .keyValidn(keyValidn_a),
        .digits(digits_a), .digitCount(digitCount_a), .full(full_a)
    );

    keypad_digit_entry #(.NUM_KEYS(12)) dut_b (
        .clk(clk), .rst(rst), .keypad(keypad_b), .enablen(enablen_b), .clear(clear_b),
        .keyCode(keyCode_b), .keyStrobe(keyStrobe_b), .keyValidn(keyValidn_b),
        .digits(digits_b), .digitCount(digitCount_b), .full(full_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge, score any strobe.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        sa = 1'b0;
        sb = 1'b0;
        if (keyStrobe_a === 1'b1) begin
            sa = 1'b1;
            n_strobe_a++;
            if (q_a.size() == 0) begin
                check("strobe_a_unexpected", 32'(keyCode_a), 32'hFFFF);
            end else begin
                e = q_a.pop_front();
                check("strobe_a", {7'd0, keyCode_a, digits_a, digitCount_a, full_a},
                      {7'd0, e.code, e.dig, e.cnt, e.full});
            end
        end
        if (keyStrobe_b === 1'b1) begin
            sb = 1'b1;
            n_strobe_b++;
            if (q_b.size() == 0) begin
                check("strobe_b_unexpected", 32'(keyCode_b), 32'hFFFF);
            end else begin
                e = q_b.pop_front();
                check("strobe_b", {7'd0, keyCode_b, digits_b, digitCount_b, full_b},
                      {7'd0, e.code, e.dig, e.cnt, e.full});
            end
        end
    endtask

    task automatic press(input bit which, input int idx, input int hold);
        if (which) begin
            keypad_b = '0;
            keypad_b[idx] = 1'b1;
        end else begin
            keypad_a = '0;
            keypad_a[idx] = 1'b1;
        end
        repeat (hold) tick();
        keypad_a = '0;
        keypad_b = '0;
        repeat (12) tick();
    endtask

    initial begin
        vec_t tbl[5];
        int   t;
        int   base;
        bit   found;

        tbl[0] = '{1, 12, 4'd1, 16'h0001, 4'd1, 1'b0};
        tbl[1] = '{2, 12, 4'd2, 16'h0012, 4'd2, 1'b0};
        tbl[2] = '{3, 12, 4'd3, 16'h0123, 4'd3, 1'b0};
        tbl[3] = '{4, 12, 4'd4, 16'h1234, 4'd4, 1'b1};
        tbl[4] = '{5, 12, 4'd5, 16'h2345, 4'd4, 1'b1};

        rst = 1'b1;
        keypad_a = '0; enablen_a = 1'b0; clear_a = 1'b0;
        keypad_b = '0; enablen_b = 1'b0; clear_b = 1'b0;
        repeat (3) tick();
        check("reset_state_a", {keyCode_a, keyStrobe_a, keyValidn_a, digits_a, digitCount_a, full_a},
              {4'd0, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b0});
        check("reset_state_b", {keyCode_b, keyStrobe_b, keyValidn_b, digits_b, digitCount_b, full_b},
              {4'd0, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b0});
        rst = 1'b0;
        repeat (2) tick();

        // Key 7: strobe after edge k+5 is seen at the 6th falling-edge sample.
        q_a.push_back('{4'd7, 16'h0007, 4'd1, 1'b0});
        base = n_strobe_a;
        keypad_a = '0;
        keypad_a[7] = 1'b1;
        t = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (sa) begin
                found = 1'b1;
                t = i;
            end
        end
        check("press7_latency", 32'(t), 32'd6);
        check("press7_validn_low", 32'(keyValidn_a), 32'd0);
        repeat (14) tick();
        check("press7_single_strobe", 32'(n_strobe_a - base), 32'd1);
        keypad_a = '0;
        t = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (keyValidn_a === 1'b1) begin
                found = 1'b1;
                t = i;
            end
        end
        check("release7_latency", 32'(t), 32'd6);
        repeat (4) tick();

        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        check("clear_a", {digits_a, digitCount_a, full_a}, {16'h0000, 4'd0, 1'b0});

        for (int i = 0; i < 5; i++) begin
            q_a.push_back('{tbl[i].code, tbl[i].dig, tbl[i].cnt, tbl[i].full});
            press(1'b0, tbl[i].key, tbl[i].hold);
        end
        check("table_drained", 32'(q_a.size()), 32'd0);
        check("after_five_digits", {digits_a, digitCount_a, full_a}, {16'h2345, 4'd4, 1'b1});

        // Key 3 with 2-sample glitches, then stable.
        base = n_strobe_a;
        for (int i = 0; i < 3; i++) begin
            keypad_a = '0;
            keypad_a[3] = 1'b1;
            repeat (2) tick();
            keypad_a = '0;
            repeat (2) tick();
        end
        q_a.push_back('{4'd3, 16'h3453, 4'd4, 1'b1});
        press(1'b0, 3, 20);
        check("glitch_then_stable_strobes", 32'(n_strobe_a - base), 32'd1);

        // Glitch-only burst: 3 high samples never reach 4.
        base = n_strobe_a;
        for (int i = 0; i < 4; i++) begin
            keypad_a = '0;
            keypad_a[3] = 1'b1;
            repeat (3) tick();
            keypad_a = '0;
            tick();
        end
        repeat (12) tick();
        check("glitch_only_strobes", 32'(n_strobe_a - base), 32'd0);

        // Two keys at once from IDLE are ignored.
        base = n_strobe_a;
        keypad_a = '0;
        keypad_a[2] = 1'b1;
        keypad_a[5] = 1'b1;
        repeat (12) tick();
        keypad_a = '0;
        repeat (10) tick();
        check("multikey_idle_strobes", 32'(n_strobe_a - base), 32'd0);

        // Hold 2, add 5 while HELD, drop 2: still one press.
        q_a.push_back('{4'd2, 16'h4532, 4'd4, 1'b1});
        keypad_a = '0;
        keypad_a[2] = 1'b1;
        repeat (10) tick();
        keypad_a[5] = 1'b1;
        repeat (10) tick();
        keypad_a[2] = 1'b0;
        repeat (5) tick();
        keypad_a = '0;
        repeat (12) tick();
        check("multikey_held_strobes", 32'(n_strobe_a - base), 32'd1);
        check("multikey_held_code", 32'(keyCode_a), 32'd2);

        // enablen high while debouncing key 9.
        base = n_strobe_a;
        keypad_a = '0;
        keypad_a[9] = 1'b1;
        repeat (3) tick();
        enablen_a = 1'b1;
        keypad_a = '0;
        repeat (6) tick();
        enablen_a = 1'b0;
        repeat (10) tick();
        check("enablen_no_strobe", 32'(n_strobe_a - base), 32'd0);
        check("enablen_digits_held", {digits_a, digitCount_a}, {16'h4532, 4'd4});

        // Asynchronous reset while key 6 is HELD.
        q_a.push_back('{4'd6, 16'h5326, 4'd4, 1'b1});
        keypad_a = '0;
        keypad_a[6] = 1'b1;
        repeat (8) tick();
        check("held6_validn", 32'(keyValidn_a), 32'd0);
        base = n_strobe_a;
        rst = 1'b1;
        keypad_a = '0;
        #1;
        check("async_reset_a", {keyCode_a, keyStrobe_a, keyValidn_a, digits_a, digitCount_a, full_a},
              {4'd0, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b0});
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check("after_reset_no_strobe", 32'(n_strobe_a - base), 32'd0);

        // 12-key instance: digit, non-digit key 11, then clear on an accept edge.
        base = n_strobe_b;
        q_b.push_back('{4'd8, 16'h0008, 4'd1, 1'b0});
        press(1'b1, 8, 12);
        q_b.push_back('{4'd11, 16'h0008, 4'd1, 1'b0});
        press(1'b1, 11, 12);
        check("key11_code", 32'(keyCode_b), 32'd11);
        check("key11_digits_unchanged", {digits_b, digitCount_b}, {16'h0008, 4'd1});
        q_b.push_back('{4'd4, 16'h0000, 4'd0, 1'b0});
        keypad_b = '0;
        keypad_b[4] = 1'b1;
        repeat (5) tick();
        clear_b = 1'b1;
        tick();
        clear_b = 1'b0;
        check("clear_on_accept_strobe_seen", 32'(sb), 32'd1);
        repeat (10) tick();
        keypad_b = '0;
        repeat (12) tick();
        check("b_strobe_count", 32'(n_strobe_b - base), 32'd3);
        check("b_after_clear", {keyCode_b, digits_b, digitCount_b, full_b}, {4'd4, 16'h0000, 4'd0, 1'b0});

        check("queue_a_empty", 32'(q_a.size()), 32'd0);
        check("queue_b_empty", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
